// File: rtl/rr_pop_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin pop arbiter.
//   NUM_FIFOS_DEF : default number of source FIFOs (power of two, 2..8)
//   DATA_SIZE_DEF : default FIFO word width
//   CNT_SIZE_DEF  : default transfer counter width
//   idx_width()   : bits needed to index n sources
package rr_pop_arbiter_pkg;

  localparam int unsigned NUM_FIFOS_DEF = 4;
  localparam int unsigned DATA_SIZE_DEF = 6;
  localparam int unsigned CNT_SIZE_DEF  = 8;

  // A single source still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pop_arbiter_if.sv
// Bus bundle between the source FIFO bank, the arbiter and the destination FIFO.
//   master : arbiter side (drives pops, pushes, counter and idle)
//   slave  : FIFO/environment side (drives empty flags, data, almost_full)
interface rr_pop_arbiter_if
  import rr_pop_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = NUM_FIFOS_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned CNT_SIZE  = CNT_SIZE_DEF
);

  localparam int unsigned IDX_W = idx_width(NUM_FIFOS);

  logic [NUM_FIFOS-1:0]           fifo_empty;
  logic [NUM_FIFOS*DATA_SIZE-1:0] fifo_data;
  logic [NUM_FIFOS-1:0]           fifo_read;
  logic                           dest_almost_full;
  logic                           dest_write;
  logic [DATA_SIZE-1:0]           dest_data;
  logic [IDX_W-1:0]               dest_src;
  logic [CNT_SIZE-1:0]            xfer_count;
  logic                           idle;

  modport master (
    input  fifo_empty, fifo_data, dest_almost_full,
    output fifo_read, dest_write, dest_data, dest_src, xfer_count, idle
  );

  modport slave (
    output fifo_empty, fifo_data, dest_almost_full,
    input  fifo_read, dest_write, dest_data, dest_src, xfer_count, idle
  );

endinterface

// File: rtl/rr_pop_arbiter_grant.sv
// Combinational round-robin priority encoder.
//   req       : request vector (bit i = source i has data)
//   ptr       : index searched first; search continues ptr+1, ... modulo NUM_FIFOS
//   grant     : first requesting index found (0 when nothing requests)
//   any_grant : at least one request present
module rr_pop_arbiter_grant
  import rr_pop_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_FIFOS = NUM_FIFOS_DEF,
  localparam int unsigned IDX_W     = idx_width(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     grant,
  output logic                 any_grant
);

  logic [IDX_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest request wins;
  // index arithmetic wraps naturally because NUM_FIFOS is a power of two.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
      idx = ptr + IDX_W'(NUM_FIFOS - 1 - k);
      if (req[idx]) grant = idx;
    end
  end

  assign any_grant = |req;

endmodule

// File: rtl/rr_pop_arbiter.sv
// Drains a bank of FIFOs in round-robin order into one destination FIFO.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : master side of rr_pop_arbiter_if
//           fifo_read is a Mealy pop strobe; source data arrives one cycle
//           after the pop and is pushed the cycle after that (latency 2).
//           idle is combinational.
module rr_pop_arbiter
  import rr_pop_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = NUM_FIFOS_DEF,
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned CNT_SIZE  = CNT_SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  rr_pop_arbiter_if.master  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_FIFOS);

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant;
  logic                 any_req;
  logic                 pop_ok;
  logic [NUM_FIFOS-1:0] fifo_read_c;
  logic                 v1;
  logic [IDX_W-1:0]     s1;
  logic [DATA_SIZE-1:0] sel_word;
  logic                 dest_write_q;
  logic [DATA_SIZE-1:0] dest_data_q;
  logic [IDX_W-1:0]     dest_src_q;
  logic [CNT_SIZE-1:0]  xfer_count_q;

  rr_pop_arbiter_grant #(.NUM_FIFOS(NUM_FIFOS)) u_grant (
    .req       (~bus.fifo_empty),
    .ptr       (rr_ptr),
    .grant     (grant),
    .any_grant (any_req)
  );

  // Almost-full is only consulted here; words already popped still drain.
  assign pop_ok = !reset && !bus.dest_almost_full && any_req;

  // One-hot pop strobe for the granted source.
  always_comb begin
    fifo_read_c = '0;
    if (pop_ok) fifo_read_c[grant] = 1'b1;
  end

  // Select the word the source presented one cycle after its pop.
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (s1 == IDX_W'(i)) sel_word = bus.fifo_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Pointer, two-stage pipeline and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      v1           <= 1'b0;
      s1           <= '0;
      dest_write_q <= 1'b0;
      dest_data_q  <= '0;
      dest_src_q   <= '0;
      xfer_count_q <= '0;
    end else begin
      if (pop_ok) rr_ptr <= grant + IDX_W'(1);
      v1           <= pop_ok;
      s1           <= grant;
      dest_write_q <= v1;
      if (v1) begin
        dest_data_q  <= sel_word;
        dest_src_q   <= s1;
        xfer_count_q <= xfer_count_q + CNT_SIZE'(1);
      end
    end
  end

  assign bus.fifo_read  = fifo_read_c;
  assign bus.dest_write = dest_write_q;
  assign bus.dest_data  = dest_data_q;
  assign bus.dest_src   = dest_src_q;
  assign bus.xfer_count = xfer_count_q;
  assign bus.idle       = (fifo_read_c == '0) && !v1 && !dest_write_q;

endmodule

// File: doc/rr_pop_arbiter.md
Name: rr_pop_arbiter

Overview:
- Downstream consumer of the bank of main FIFOs. Drains NUM_FIFOS FIFO instances in round-robin order and pushes each word into a single destination FIFO.
- Pops only when the source FIFO is non-empty and the destination is not almost full.
- Pairs with the FIFO's registered read port (buff_out valid one cycle after read) and its almost_full threshold output.

Parameters:
- NUM_FIFOS, 4, number of source FIFOs; power of two, 2..8.
- DATA_SIZE, 6, word width of every FIFO.
- CNT_SIZE, 8, width of the transfer counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  NUM_FIFOS  per-source empty flag (bit i = FIFO i).
- fifo_data  input  NUM_FIFOS*DATA_SIZE  concatenated buff_out of the sources; FIFO i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- fifo_read  output  NUM_FIFOS  one-hot pop strobe to the sources.
- dest_almost_full  input  1  destination almost_full flag.
- dest_write  output  1  push strobe to the destination.
- dest_data  output  DATA_SIZE  word pushed to the destination.
- dest_src  output  clog2(NUM_FIFOS)  index of the source that produced dest_data.
- xfer_count  output  CNT_SIZE  total words pushed since reset; wraps.
- idle  output  1  high when nothing is popped or in flight this cycle.

Behaviour:
- Reset (reset=1 sampled at a posedge):
  - dest_write=0, dest_data=0, dest_src=0, xfer_count=0.
  - rr_ptr=0; in-flight stage cleared.
  - fifo_read=0 while reset is high.
- Reset mid-operation discards in-flight words: no dest_write in the cycle after reset is sampled.
- Grant (combinational, Mealy):
  - Allowed when reset=0, dest_almost_full=0 and any fifo_empty bit is 0.
  - Grant = first non-empty index searching rr_ptr, rr_ptr+1, ... modulo NUM_FIFOS.
  - fifo_read = one-hot(grant) when allowed, else 0.
  - At most one pop per cycle, and never to an empty FIFO.
- Pointer: on a granted cycle, rr_ptr <= grant+1 (wraps NUM_FIFOS-1 -> 0). Unchanged otherwise.
- Pipeline:
  - Stage 1 (edge after the pop): v1<=1, s1<=grant. FIFO updates buff_out at the same edge.
  - Stage 2 (edge after stage 1): if v1, then dest_write<=1, dest_data<=fifo_data[s1], dest_src<=s1, xfer_count<=xfer_count+1. Else dest_write<=0.
  - Latency: pop in cycle t -> dest_write high in cycle t+2.
  - Throughput: 1 word/cycle sustained.
- Backpressure:
  - dest_almost_full is checked only at grant time.
  - Up to 2 words (v1 and output stage) may still be pushed after it rises.
  - The destination must set umb_almost_full to leave ≥2 free entries.
  - Pops resume in the first cycle dest_almost_full is low.
- Empty-flag lag: the source's fifo_empty is registered and is valid the cycle after a pop. Popping the last entry in cycle t gives empty=1 in t+1, so no double pop occurs.
- Simultaneous requests: a single-source stream gets every cycle. With all sources non-empty, the order is 0,1,2,3,0,...
- idle = (fifo_read==0) && !v1 && !dest_write.
- xfer_count wraps 2^CNT_SIZE-1 -> 0 without saturation.

Decomposition:
- Shared package: DATA_SIZE default, NUM_FIFOS default, and a function computing the index width (clog2).
- Natural sub-module: rr_grant, a combinational round-robin priority encoder.
  - Inputs: request vector (~fifo_empty), rr_ptr.
  - Outputs: grant index, any_grant.
- The top level holds the pointer, the pipeline and the counter.

Test Plan:
- Reset: hold reset 3 cycles with all FIFOs non-empty -> fifo_read=0, dest_write=0, xfer_count=0 throughout. First pop is to FIFO 0 in the cycle after reset drops.
- Single source: FIFO 2 holds 'h3,'h4,'h5; others empty. -> fifo_read='b0100 for 3 consecutive cycles. dest_write high 2 cycles later with dest_data 'h3,'h4,'h5, dest_src=2, xfer_count=3. No fourth pop.
- Fairness: all 4 FIFOs hold 2 words. -> dest_src sequence 0,1,2,3,0,1,2,3 back-to-back, xfer_count=8, then idle=1.
- Backpressure: raise dest_almost_full mid-stream. -> fifo_read=0 the same cycle, at most 2 further dest_write, none after. Dropping it resumes pops at the saved rr_ptr.
- Wrap: preload xfer_count path with 256 words -> xfer_count returns to 0, no stall. rr_ptr wraps 3->0 correctly.
- Reset mid-flight: assert reset the cycle after a pop -> no dest_write for that word. rr_ptr=0 afterward.
